// File: rtl/riscv_wb_arbiter.sv
// Register-file write-port arbiter.
// The in-order writeback result has priority. Long-latency divider results
// wait in a small FIFO and drain on cycles the pipeline leaves the port idle.
// A starvation counter forces a one-cycle stall so the FIFO always drains.
// Entries whose rd is overwritten by a younger writeback are killed so they
// cannot clobber the newer value.
module riscv_wb_arbiter #(
  parameter int XLEN         = 64,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            i_riscv_wbarb_clk,
  input  logic            i_riscv_wbarb_rst,
  input  logic            i_riscv_wbarb_pipe_regwrite,
  input  logic [4:0]      i_riscv_wbarb_pipe_rdaddr,
  input  logic [XLEN-1:0] i_riscv_wbarb_pipe_rddata,
  input  logic            i_riscv_wbarb_div_valid,
  input  logic [4:0]      i_riscv_wbarb_div_rdaddr,
  input  logic [XLEN-1:0] i_riscv_wbarb_div_rddata,
  output logic            o_riscv_wbarb_div_ready,
  output logic            o_riscv_wbarb_rf_we,
  output logic [4:0]      o_riscv_wbarb_rf_waddr,
  output logic [XLEN-1:0] o_riscv_wbarb_rf_wdata,
  output logic            o_riscv_wbarb_stall,
  output logic            o_riscv_wbarb_pending
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(STARVE_LIMIT) + 1;
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] FORCE_AT = CW'(STARVE_LIMIT - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } state_t;

  logic clk;
  logic srst;
  assign clk  = i_riscv_wbarb_clk;
  assign srst = i_riscv_wbarb_rst;

  state_t            state_reg, state_next;
  logic [CW-1:0]     starve_cnt_reg, starve_cnt_next;
  logic [AW-1:0]     rd_ptr_reg, wr_ptr_reg;
  logic [AW:0]       count_reg, count_next;
  logic [4:0]        mem_addr [DEPTH];
  logic [XLEN-1:0]   mem_data [DEPTH];
  logic [DEPTH-1:0]  kill_reg, kill_next;
  logic [4:0]        hold_addr_reg;
  logic [XLEN-1:0]   hold_data_reg;

  logic            pipe_wr, pipe_do, in_force;
  logic            fifo_empty, fifo_full;
  logic            push, pop, push_killed;
  logic [4:0]      head_addr;
  logic [XLEN-1:0] head_data;
  logic            head_live;
  logic            port_we;
  logic [4:0]      port_addr;
  logic [XLEN-1:0] port_data;
  logic [CW-1:0]   cnt_inc;

  assign pipe_wr    = i_riscv_wbarb_pipe_regwrite & (i_riscv_wbarb_pipe_rdaddr != 5'd0);
  assign in_force   = (state_reg == FORCE);
  // During a forced drain the pipe write is dropped; the pipeline re-presents it.
  assign pipe_do    = pipe_wr & ~in_force;
  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == FULL_CNT);
  assign push       = i_riscv_wbarb_div_valid & ~fifo_full & ~srst;
  assign pop        = ~fifo_empty & (in_force | ~pipe_wr);
  assign count_next = count_reg + (AW + 1)'(push) - (AW + 1)'(pop);

  assign head_addr  = mem_addr[rd_ptr_reg];
  assign head_data  = mem_data[rd_ptr_reg];
  assign head_live  = ~kill_reg[rd_ptr_reg] & (head_addr != 5'd0);
  // A result pushed alongside a same-rd writeback is older than it: born dead.
  assign push_killed = pipe_do & (i_riscv_wbarb_div_rdaddr == i_riscv_wbarb_pipe_rdaddr);

  assign cnt_inc = (starve_cnt_reg == CNT_MAX) ? CNT_MAX : starve_cnt_reg + 1'b1;

  // Per-entry kill bits: cleared on refill, set by a younger same-rd writeback.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_kill
      assign kill_next[gi] =
          (push && (wr_ptr_reg == AW'(gi))) ? push_killed :
          ((pipe_do && (mem_addr[gi] == i_riscv_wbarb_pipe_rdaddr)) ? 1'b1 : kill_reg[gi]);
    end
  endgenerate

  // Write-port selection: writeback first, otherwise the FIFO head when popped.
  always_comb begin
    port_we   = 1'b0;
    port_addr = hold_addr_reg;
    port_data = hold_data_reg;
    if (pipe_do) begin
      port_we   = 1'b1;
      port_addr = i_riscv_wbarb_pipe_rdaddr;
      port_data = i_riscv_wbarb_pipe_rddata;
    end else if (pop && head_live) begin
      port_we   = 1'b1;
      port_addr = head_addr;
      port_data = head_data;
    end
  end

  // Drive outputs; everything reads as zero while reset is held.
  always_comb begin
    o_riscv_wbarb_rf_we     = port_we;
    o_riscv_wbarb_rf_waddr  = port_addr;
    o_riscv_wbarb_rf_wdata  = port_data;
    o_riscv_wbarb_stall     = in_force;
    o_riscv_wbarb_pending   = ~fifo_empty;
    o_riscv_wbarb_div_ready = ~fifo_full;
    if (srst) begin
      o_riscv_wbarb_rf_we     = 1'b0;
      o_riscv_wbarb_rf_waddr  = '0;
      o_riscv_wbarb_rf_wdata  = '0;
      o_riscv_wbarb_stall     = 1'b0;
      o_riscv_wbarb_pending   = 1'b0;
      o_riscv_wbarb_div_ready = 1'b0;
    end
  end

  // Next-state and starvation counter; the counter value including this
  // blocked cycle reaching STARVE_LIMIT-1 schedules a forced drain.
  always_comb begin
    state_next      = state_reg;
    starve_cnt_next = starve_cnt_reg;
    case (state_reg)
      IDLE: begin
        starve_cnt_next = '0;
        if (push) state_next = PEND;
      end
      PEND: begin
        if (pop) begin
          starve_cnt_next = '0;
          if (count_next == '0) state_next = IDLE;
        end else begin
          starve_cnt_next = cnt_inc;
          if (cnt_inc >= FORCE_AT) state_next = FORCE;
        end
      end
      FORCE: begin
        starve_cnt_next = '0;
        state_next      = (count_next != '0) ? PEND : IDLE;
      end
      default: begin
        state_next      = IDLE;
        starve_cnt_next = '0;
      end
    endcase
  end

  // Control state, FIFO pointers and last-driven port values.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= '0;
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      count_reg      <= '0;
      kill_reg       <= '0;
      hold_addr_reg  <= '0;
      hold_data_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
      count_reg      <= count_next;
      kill_reg       <= kill_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (port_we) begin
        hold_addr_reg <= port_addr;
        hold_data_reg <= port_data;
      end
    end
  end

  // FIFO payload storage; occupancy is tracked by count_reg, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr_reg] <= i_riscv_wbarb_div_rdaddr;
      mem_data[wr_ptr_reg] <= i_riscv_wbarb_div_rddata;
    end
  end

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Scoreboard bench for riscv_wb_arbiter: expected register-file writes are
// queued by the stimulus and consumed by a monitor on every rf_we cycle.
module tb_riscv_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        pipe_regwrite;
  logic [4:0]  pipe_rdaddr;
  logic [63:0] pipe_rddata;
  logic        div_valid;
  logic [4:0]  div_rdaddr;
  logic [63:0] div_rddata;
  logic        div_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        stall;
  logic        pending;

  riscv_wb_arbiter #(.XLEN(64), .DEPTH(2), .STARVE_LIMIT(4)) dut (
    .i_riscv_wbarb_clk           (clk),
    .i_riscv_wbarb_rst           (rst),
    .i_riscv_wbarb_pipe_regwrite (pipe_regwrite),
    .i_riscv_wbarb_pipe_rdaddr   (pipe_rdaddr),
    .i_riscv_wbarb_pipe_rddata   (pipe_rddata),
    .i_riscv_wbarb_div_valid     (div_valid),
    .i_riscv_wbarb_div_rdaddr    (div_rdaddr),
    .i_riscv_wbarb_div_rddata    (div_rddata),
    .o_riscv_wbarb_div_ready     (div_ready),
    .o_riscv_wbarb_rf_we         (rf_we),
    .o_riscv_wbarb_rf_waddr      (rf_waddr),
    .o_riscv_wbarb_rf_wdata      (rf_wdata),
    .o_riscv_wbarb_stall         (stall),
    .o_riscv_wbarb_pending       (pending)
  );

  typedef struct {
    logic [4:0]  a;
    logic [63:0] d;
    logic        s;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  // Monitor: every register-file write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && rf_we) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=0x%0h stall=%0b, required no write",
                 rf_waddr, rf_wdata, stall);
      end else begin
        mon_e = sb_q.pop_front();
        if (rf_waddr !== mon_e.a || rf_wdata !== mon_e.d || stall !== mon_e.s) begin
          errors++;
          $display("FAIL rf_write: got addr=%0d data=0x%0h stall=%0b, required addr=%0d data=0x%0h stall=%0b",
                   rf_waddr, rf_wdata, stall, mon_e.a, mon_e.d, mon_e.s);
        end else begin
          $display("write ok: x%0d <= 0x%0h stall=%0b", rf_waddr, rf_wdata, stall);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [63:0] d, input logic s);
    exp_t e;
    e.a = a;
    e.d = d;
    e.s = s;
    sb_q.push_back(e);
  endtask

  // Advance to just after the next rising edge and apply this cycle's inputs.
  task automatic cyc(input logic pw, input logic [4:0] pa, input logic [63:0] pd,
                     input logic dv, input logic [4:0] da, input logic [63:0] dd);
    @(posedge clk);
    #1;
    pipe_regwrite = pw;
    pipe_rdaddr   = pa;
    pipe_rddata   = pd;
    div_valid     = dv;
    div_rdaddr    = da;
    div_rddata    = dd;
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
  endtask

  initial begin
    rst           = 1'b1;
    pipe_regwrite = 1'b0;
    pipe_rdaddr   = 5'd0;
    pipe_rddata   = 64'd0;
    div_valid     = 1'b1;
    div_rdaddr    = 5'd5;
    div_rddata    = 64'h5555;

    // Reset held three cycles with a divider result offered.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_rf_we", {63'd0, rf_we}, 64'd0);
      check("rst_div_ready", {63'd0, div_ready}, 64'd0);
      check("rst_stall", {63'd0, stall}, 64'd0);
      check("rst_waddr", {59'd0, rf_waddr}, 64'd0);
    end
    @(posedge clk);
    #1;
    rst       = 1'b0;
    div_valid = 1'b0;
    @(negedge clk);
    check("post_rst_div_ready", {63'd0, div_ready}, 64'd1);
    check("post_rst_pending", {63'd0, pending}, 64'd0);

    // Idle drain: x5=0xDEAD is written the cycle after the push.
    cyc(1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 64'hDEAD);
    expect_wr(5'd5, 64'hDEAD, 1'b0);
    @(negedge clk);
    check("drain_pending_before", {63'd0, pending}, 64'd0);
    idle();
    @(negedge clk);
    check("drain_pending_during", {63'd0, pending}, 64'd1);
    check("drain_rf_we", {63'd0, rf_we}, 64'd1);
    idle();
    @(negedge clk);
    check("drain_pending_after", {63'd0, pending}, 64'd0);

    // Starvation: x7 blocked by x1..x3, forced out when x4 is presented.
    cyc(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'h11);
    cyc(1'b1, 5'd1, 64'h101, 1'b0, 5'd0, 64'd0);
    expect_wr(5'd1, 64'h101, 1'b0);
    @(negedge clk);
    check("starve_stall_c1", {63'd0, stall}, 64'd0);
    cyc(1'b1, 5'd2, 64'h102, 1'b0, 5'd0, 64'd0);
    expect_wr(5'd2, 64'h102, 1'b0);
    cyc(1'b1, 5'd3, 64'h103, 1'b0, 5'd0, 64'd0);
    expect_wr(5'd3, 64'h103, 1'b0);
    @(negedge clk);
    check("starve_stall_c3", {63'd0, stall}, 64'd0);
    cyc(1'b1, 5'd4, 64'h104, 1'b0, 5'd0, 64'd0);
    expect_wr(5'd7, 64'h11, 1'b1);
    @(negedge clk);
    check("force_stall", {63'd0, stall}, 64'd1);
    cyc(1'b1, 5'd4, 64'h104, 1'b0, 5'd0, 64'd0);
    expect_wr(5'd4, 64'h104, 1'b0);
    @(negedge clk);
    check("after_force_stall", {63'd0, stall}, 64'd0);
    check("after_force_pending", {63'd0, pending}, 64'd0);

    // WAW kill: buffered x9=0xAA overwritten by younger pipe x9=0xBB.
    cyc(1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 64'hAA);
    cyc(1'b1, 5'd9, 64'hBB, 1'b0, 5'd0, 64'd0);
    expect_wr(5'd9, 64'hBB, 1'b0);
    idle();
    @(negedge clk);
    check("waw_pop_silent", {63'd0, rf_we}, 64'd0);
    check("waw_pending_during", {63'd0, pending}, 64'd1);
    idle();
    @(negedge clk);
    check("waw_pending_after", {63'd0, pending}, 64'd0);

    // WAW kill with the push and the pipe write in the same cycle.
    cyc(1'b1, 5'd9, 64'hDD, 1'b1, 5'd9, 64'hCC);
    expect_wr(5'd9, 64'hDD, 1'b0);
    idle();
    @(negedge clk);
    check("waw_same_pop_silent", {63'd0, rf_we}, 64'd0);
    idle();
    @(negedge clk);
    check("waw_same_pending_after", {63'd0, pending}, 64'd0);

    // Full FIFO: x3 is held off until a slot frees; order x10, x11, x3.
    cyc(1'b1, 5'd20, 64'h200, 1'b1, 5'd10, 64'hA0);
    expect_wr(5'd20, 64'h200, 1'b0);
    cyc(1'b1, 5'd21, 64'h210, 1'b1, 5'd11, 64'hB0);
    expect_wr(5'd21, 64'h210, 1'b0);
    cyc(1'b1, 5'd22, 64'h220, 1'b1, 5'd3, 64'h33);
    expect_wr(5'd22, 64'h220, 1'b0);
    @(negedge clk);
    check("full_div_ready", {63'd0, div_ready}, 64'd0);
    check("full_pending", {63'd0, pending}, 64'd1);
    cyc(1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 64'h33);
    expect_wr(5'd10, 64'hA0, 1'b0);
    @(negedge clk);
    check("full_pop_div_ready", {63'd0, div_ready}, 64'd0);
    cyc(1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 64'h33);
    expect_wr(5'd11, 64'hB0, 1'b0);
    @(negedge clk);
    check("freed_div_ready", {63'd0, div_ready}, 64'd1);
    idle();
    expect_wr(5'd3, 64'h33, 1'b0);
    idle();
    @(negedge clk);
    check("full_pending_after", {63'd0, pending}, 64'd0);

    // x0: neither the pipe write nor the divider result reaches the file.
    cyc(1'b1, 5'd0, 64'h55, 1'b1, 5'd0, 64'h77);
    @(negedge clk);
    check("x0_pipe_no_we", {63'd0, rf_we}, 64'd0);
    cyc(1'b1, 5'd0, 64'h55, 1'b0, 5'd0, 64'd0);
    @(negedge clk);
    check("x0_pop_no_we", {63'd0, rf_we}, 64'd0);
    check("x0_pending_during", {63'd0, pending}, 64'd1);
    idle();
    @(negedge clk);
    check("x0_pending_after", {63'd0, pending}, 64'd0);

    // Reset while an entry is buffered discards it.
    cyc(1'b1, 5'd13, 64'h13, 1'b1, 5'd12, 64'h12);
    expect_wr(5'd13, 64'h13, 1'b0);
    idle();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_rf_we", {63'd0, rf_we}, 64'd0);
    check("midrst_pending", {63'd0, pending}, 64'd0);
    idle();
    rst = 1'b0;
    @(negedge clk);
    check("postrst_pending", {63'd0, pending}, 64'd0);
    check("postrst_rf_we", {63'd0, rf_we}, 64'd0);
    idle();
    idle();
    @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
